riscv_alu_issue: RTL and testbench

//  Driver side of the ALU operand interface: decodes a RISC-V instruction word into alu_op/op1/op2.

---
 rtl/riscv_alu_issue.sv | 229 ++++++++++++++++++++++
 tb/tb_riscv_alu_issue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_alu_issue.sv
// ALU issue stage: decodes a RISC-V instruction into ALU operands and opcode,
// holds the result in a single valid/ready register stage, and counts
// encodings the ALU cannot execute.
module riscv_alu_issue #(
  parameter int unsigned COUNT_W  = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [31:0]        in_rs1_data,
  input  logic [31:0]        in_rs2_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_op1,
  output logic [31:0]        out_op2,
  output logic [3:0]         out_alu_op,
  output logic [4:0]         out_rd,
  output logic               out_wb_en,
  output logic               out_illegal,
  output logic [COUNT_W-1:0] illegal_cnt
);

  typedef enum logic [3:0] {
    AluAnd = 4'b0000,
    AluOr  = 4'b0001,
    AluAdd = 4'b0010,
    AluSub = 4'b0110,
    AluSlt = 4'b0111,
    AluSrl = 4'b1000,
    AluSll = 4'b1001,
    AluSra = 4'b1010,
    AluXor = 4'b1101
  } alu_op_e;

  localparam logic [6:0] OpcReg    = 7'b0110011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic        rd_nz;

  // rs1/rs2 indices are resolved by the register file upstream
  logic unused_rs_idx;
  assign unused_rs_idx = ^in_instr[19:15];

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rd     = in_instr[11:7];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign rd_nz  = (rd != 5'd0);

  alu_op_e     dec_alu_op;
  logic [31:0] dec_op1;
  logic [31:0] dec_op2;
  logic        dec_wb_en;
  logic        dec_legal;

  // Instruction decode; illegal encodings collapse to a harmless ADD 0,0
  always_comb begin
    dec_alu_op = AluAdd;
    dec_op2    = 32'd0;
    dec_wb_en  = 1'b0;
    dec_legal  = 1'b0;
    unique case (opcode)
      OpcReg: begin
        dec_op2   = in_rs2_data;
        dec_wb_en = rd_nz;
        if (funct7 == F7Base) begin
          dec_legal = 1'b1;
          unique case (funct3)
            3'b000:  dec_alu_op = AluAdd;
            3'b001:  dec_alu_op = AluSll;
            3'b010:  dec_alu_op = AluSlt;
            3'b100:  dec_alu_op = AluXor;
            3'b101:  dec_alu_op = AluSrl;
            3'b110:  dec_alu_op = AluOr;
            3'b111:  dec_alu_op = AluAnd;
            default: dec_legal  = 1'b0;  // SLTU
          endcase
        end else if (funct7 == F7Alt) begin
          if (funct3 == 3'b000) begin
            dec_legal  = 1'b1;
            dec_alu_op = AluSub;
          end else if (funct3 == 3'b101) begin
            dec_legal  = 1'b1;
            dec_alu_op = AluSra;
          end
        end
      end
      OpcImm: begin
        dec_op2   = imm_i;
        dec_wb_en = rd_nz;
        unique case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_alu_op = AluAdd; end
          3'b010: begin dec_legal = 1'b1; dec_alu_op = AluSlt; end
          3'b100: begin dec_legal = 1'b1; dec_alu_op = AluXor; end
          3'b110: begin dec_legal = 1'b1; dec_alu_op = AluOr;  end
          3'b111: begin dec_legal = 1'b1; dec_alu_op = AluAnd; end
          3'b001: begin
            dec_legal  = (funct7 == F7Base);
            dec_alu_op = AluSll;
          end
          3'b101: begin
            if (funct7 == F7Base) begin
              dec_legal  = 1'b1;
              dec_alu_op = AluSrl;
            end else if (funct7 == F7Alt) begin
              dec_legal  = 1'b1;
              dec_alu_op = AluSra;
            end
          end
          default: dec_legal = 1'b0;  // SLTIU
        endcase
      end
      OpcLoad: begin
        dec_legal = 1'b1;
        dec_op2   = imm_i;
        dec_wb_en = rd_nz;
      end
      OpcStore: begin
        dec_legal = 1'b1;
        dec_op2   = imm_s;
      end
      OpcBranch: begin
        dec_op2    = in_rs2_data;
        dec_alu_op = AluSub;
        dec_legal  = (funct3 == 3'b000) || (funct3 == 3'b001);
      end
      default: dec_legal = 1'b0;
    endcase

    if (!dec_legal) begin
      dec_alu_op = AluAdd;
      dec_op2    = 32'd0;
      dec_wb_en  = 1'b0;
    end
    dec_op1 = dec_legal ? in_rs1_data : 32'd0;
  end

  logic               valid_q, valid_d;
  logic [31:0]        op1_q, op1_d;
  logic [31:0]        op2_q, op2_d;
  logic [3:0]         alu_op_q, alu_op_d;
  logic [4:0]         rd_q, rd_d;
  logic               wb_en_q, wb_en_d;
  logic               illegal_q, illegal_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               accept;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Next-state: flush wins over capture; a consume without capture only drops valid
  always_comb begin
    valid_d   = valid_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    alu_op_d  = alu_op_q;
    rd_d      = rd_q;
    wb_en_d   = wb_en_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      op1_d     = dec_op1;
      op2_d     = dec_op2;
      alu_op_d  = dec_alu_op;
      rd_d      = rd;
      wb_en_d   = dec_wb_en;
      illegal_d = !dec_legal;
      if (!dec_legal && !(SATURATE && (&cnt_q))) begin
        cnt_d = cnt_q + COUNT_W'(1);
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      op1_q     <= 32'd0;
      op2_q     <= 32'd0;
      alu_op_q  <= AluAdd;
      rd_q      <= 5'd0;
      wb_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      alu_op_q  <= alu_op_d;
      rd_q      <= rd_d;
      wb_en_q   <= wb_en_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_op1     = op1_q;
  assign out_op2     = op2_q;
  assign out_alu_op  = alu_op_q;
  assign out_rd      = rd_q;
  assign out_wb_en   = wb_en_q;
  assign out_illegal = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_alu_issue.sv
// Randomized scoreboard bench for riscv_alu_issue, with a second small
// saturating-counter instance sharing the same stimulus.
module tb_riscv_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'd0;
  logic [31:0] in_rs1_data = 32'd0;
  logic [31:0] in_rs2_data = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  logic        unused_ready2, unused_valid2, unused_wb2, unused_ill2;
  logic [31:0] unused_op1_2, unused_op2_2;
  logic [3:0]  unused_alu2;
  logic [4:0]  unused_rd2;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  riscv_alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_alu_op(out_alu_op), .out_rd(out_rd),
    .out_wb_en(out_wb_en), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  riscv_alu_issue #(.COUNT_W(2), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(unused_ready2),
    .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .flush(flush), .out_valid(unused_valid2), .out_ready(out_ready),
    .out_op1(unused_op1_2), .out_op2(unused_op2_2), .out_alu_op(unused_alu2),
    .out_rd(unused_rd2), .out_wb_en(unused_wb2), .out_illegal(unused_ill2),
    .illegal_cnt(cnt2)
  );

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } ent_t;

  // ALU codes by mnemonic
  localparam int A_AND = 0, A_OR = 1, A_ADD = 2, A_SUB = 6, A_SLT = 7;
  localparam int A_SRL = 8, A_SLL = 9, A_SRA = 10, A_XOR = 13;

  // funct3 -> op for the base (funct7=0) R ops and the I ops; -1 = unsupported (SLTU)
  int base_tab [8] = '{A_ADD, A_SLL, A_SLT, -1, A_XOR, A_SRL, A_OR, A_AND};

  ent_t        exp_q[$];
  ent_t        last;
  ent_t        reset_ent;
  logic [15:0] m_cnt;
  int          m_cnt2;
  bit          started = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_beats = 0;

  function automatic ent_t ref_decode(logic [31:0] i, logic [31:0] r1, logic [31:0] r2);
    ent_t        e;
    int          code;
    logic [31:0] b;
    logic [6:0]  f7;
    logic [2:0]  f3;
    bit          wr;
    code = -1;
    b    = 32'd0;
    f7   = i[31:25];
    f3   = i[14:12];
    wr   = (i[11:7] != 5'd0);
    case (i[6:0])
      7'b0110011: begin
        b = r2;
        if (f7 == 7'h00) code = base_tab[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) code = A_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) code = A_SRA;
      end
      7'b0010011: begin
        b = 32'($signed(i[31:20]));
        if (f3 == 3'd1) code = (f7 == 7'h00) ? A_SLL : -1;
        else if (f3 == 3'd5) code = (f7 == 7'h00) ? A_SRL : (f7 == 7'h20) ? A_SRA : -1;
        else code = base_tab[f3];
      end
      7'b0000011: begin
        b = 32'($signed(i[31:20]));
        code = A_ADD;
      end
      7'b0100011: begin
        b = 32'($signed({i[31:25], i[11:7]}));
        code = A_ADD;
        wr = 1'b0;
      end
      7'b1100011: begin
        b = r2;
        code = (f3 < 3'd2) ? A_SUB : -1;
        wr = 1'b0;
      end
      default: code = -1;
    endcase
    e.rd = i[11:7];
    if (code < 0) begin
      e.op1 = 32'd0; e.op2 = 32'd0; e.alu = 4'(A_ADD); e.wb = 1'b0; e.ill = 1'b1;
    end else begin
      e.op1 = r1; e.op2 = b; e.alu = 4'(code); e.wb = wr; e.ill = 1'b0;
    end
    return e;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: mid-cycle compare of handshake, counters and presented entry
  always @(negedge clk) begin
    if (started) begin
      ent_t e;
      bit   have;
      have = (exp_q.size() != 0);
      e    = have ? exp_q[0] : last;
      check("in_ready", 64'(in_ready), 64'(!have || out_ready));
      check("out_valid", 64'(out_valid), 64'(have));
      check("illegal_cnt", 64'(illegal_cnt), 64'(m_cnt));
      check("illegal_cnt_sat2", 64'(cnt2), 64'(m_cnt2));
      check("out_op1", 64'(out_op1), 64'(e.op1));
      check("out_op2", 64'(out_op2), 64'(e.op2));
      check("out_alu_op", 64'(out_alu_op), 64'(e.alu));
      check("out_rd", 64'(out_rd), 64'(e.rd));
      check("out_wb_en", 64'(out_wb_en), 64'(e.wb));
      check("out_illegal", 64'(out_illegal), 64'(e.ill));
      if (have && out_valid && out_ready) begin
        void'(exp_q.pop_front());
        n_beats++;
      end
    end
  end

  // One cycle of stimulus; the model is advanced at the edge, inputs change 1 after
  task automatic cyc(bit iv, logic [31:0] ins, logic [31:0] r1, logic [31:0] r2,
                     bit ordy, bit fl, bit rs);
    bit acc;
    in_valid    = iv;
    in_instr    = ins;
    in_rs1_data = r1;
    in_rs2_data = r2;
    out_ready   = ordy;
    flush       = fl;
    rst         = rs;
    @(posedge clk);
    if (rs) begin
      exp_q.delete();
      m_cnt   = 16'd0;
      m_cnt2  = 0;
      last    = reset_ent;
      started = 1'b1;
    end else begin
      acc = iv && (ordy || exp_q.size() == 0);
      if (fl) begin
        exp_q.delete();
      end else if (acc) begin
        ent_t e;
        e = ref_decode(ins, r1, r2);
        exp_q.push_back(e);
        last = e;
        if (e.ill) begin
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc;
    logic [6:0] f7;
    logic [6:0] opcs [6];
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'h7f};
    opc = opcs[$urandom_range(5)];
    if (opc == 7'h7f) opc = 7'($urandom);
    case ($urandom_range(3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 10'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  initial begin
    reset_ent = '{op1: 32'd0, op2: 32'd0, alu: 4'b0010, rd: 5'd0, wb: 1'b0, ill: 1'b0};
    last = reset_ent;
    m_cnt = 16'd0;
    m_cnt2 = 0;

    cyc(0, 32'd0, 0, 0, 0, 0, 1);
    cyc(0, 32'd0, 0, 0, 0, 0, 1);
    cyc(0, 32'd0, 0, 0, 1, 0, 0);

    cyc(1, 32'h002081B3, 32'd5, 32'd7, 1, 0, 0);            // ADD x3,x1,x2
    cyc(1, 32'h40325213, 32'h80000000, 32'd0, 1, 0, 0);     // SRAI x4,x4,3
    cyc(1, 32'hFFF00013, 32'd9, 32'd9, 1, 0, 0);            // ADDI x0,x0,-1
    cyc(1, 32'hFE20AE23, 32'd100, 32'd1, 1, 0, 0);          // SW, negative offset
    cyc(1, 32'h00209463, 32'd3, 32'd3, 1, 0, 0);            // BNE

    // Stall for 3 cycles with input pending, then stream back-to-back
    cyc(1, 32'h0020F1B3, 32'hF0F0, 32'h0FF0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, 32'h0020E233, 32'h1234, 32'h4321, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 32'h00A00093 + (k << 20), 32'(k), 32'd0, 1, 0, 0);
    cyc(0, 32'd0, 0, 0, 1, 0, 0);

    // Illegals: SLTU then more, saturating the 2-bit counter
    cyc(1, 32'h0020B1B3, 32'd3, 32'd4, 1, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 32'hFFFFFFFF, 32'd1, 32'd2, 1, 0, 0);
    cyc(0, 32'd0, 0, 0, 1, 0, 0);

    // Flush racing an accept of an illegal entry
    cyc(1, 32'h002081B3, 32'd8, 32'd9, 0, 0, 0);
    cyc(1, 32'h0020B1B3, 32'd1, 32'd1, 1, 1, 0);
    cyc(0, 32'd0, 0, 0, 1, 0, 0);

    // Reset while an entry is held
    cyc(1, 32'h002081B3, 32'd11, 32'd12, 1, 0, 0);
    cyc(0, 32'd0, 0, 0, 0, 0, 1);
    cyc(0, 32'd0, 0, 0, 1, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(3) != 0, rand_instr(), $urandom, $urandom,
          $urandom_range(3) != 0, $urandom_range(19) == 0, $urandom_range(99) == 0);
    end
    cyc(0, 32'd0, 0, 0, 1, 0, 0);
    @(negedge clk);
    if (n_beats < 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_count: got %0d expected at least 100", n_beats);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
